// File: rtl/uart_tx_emitter.sv
// Transmit-only UART serializer (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// One byte per valid/ready handshake, shifted out LSB first; o_ready doubles as "not busy".
module uart_tx_emitter #(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 1000000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  // state | meaning
  // IDLE  | line high, ready for a byte
  // SEND  | frame being shifted out, new bytes ignored
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam int DIV = clk_freq_hz / baud_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_emitter: clk_freq_hz / baud_rate must be at least 2");
  end

  logic [0:0]            state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_load;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  accept;

`ifdef UART_TX_PARITY_EN
  assign frame_load = {1'b1, ^i_data, i_data, 1'b0};
`else
  assign frame_load = {1'b1, i_data, 1'b0};
`endif

  assign accept    = i_valid && (state == IDLE);
  assign o_ready   = (state == IDLE);
  assign o_uart_tx = (state == SEND) ? shift_reg[0] : 1'b1;

  // bit_cnt holds the number of bits still to go after the one on the line
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state     <= IDLE;
      shift_reg <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND;
            shift_reg <= frame_load;
            baud_cnt  <= BAUD_RELOAD;
            bit_cnt   <= LAST_BIT;
          end
        end
        SEND: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == '0) begin
              state <= IDLE;
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_emitter.sv
// Scoreboard bench for uart_tx_emitter: a cycle-level reference model predicts
// acceptance and busy time, a negedge monitor checks every line sample of every frame.
module tb_uart_tx_emitter;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 250;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_emitter #(.clk_freq_hz(CLK_HZ), .baud_rate(BAUD)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_uart_tx(tx)
  );

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } item_t;

  item_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    busy_until  = 0;
  int    accept_cnt  = 0;

  // line value of frame bit idx for byte b: start, d0..d7, [even parity], stop
  function automatic logic frame_bit(logic [7:0] b, int idx);
    logic [7:0] t;
    if (idx == 0) return 1'b0;
    if (idx <= 8) begin
      t = b >> (idx - 1);
      return t[0];
    end
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // reference model: a frame occupies FB*DIV cycles from its accepting edge
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_until = 0;
    end else if (valid && cyc >= busy_until) begin
      exp_q.push_back(item_t'{b: data, cyc: cyc + 1});
      busy_until = cyc + 1 + FB * DIV;
      accept_cnt++;
    end
    cyc++;
  end

  logic  in_frame = 1'b0;
  logic  junk     = 1'b0;
  int    pos      = 0;
  int    errs     = 0;
  item_t cur;

  always @(negedge clk) begin
    check("ready", int'(ready), int'(!rst_n || cyc >= busy_until));
    if (!rst_n) begin
      in_frame = 1'b0;
      junk     = 1'b0;
      check("reset_tx", int'(tx), 1);
    end else if (in_frame) begin
      if (pos < FB * DIV) begin
        if (tx !== frame_bit(cur.b, pos / DIV)) errs++;
        pos++;
      end else begin
        if (tx !== 1'b1) errs++;
        check($sformatf("frame_%02h_bad_samples", cur.b), errs, 0);
        in_frame = 1'b0;
      end
    end else if (junk) begin
      if (tx === 1'b1) junk = 1'b0;
    end else if (tx !== 1'b1) begin
      check("start_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() == 0) begin
        junk = 1'b1;
      end else begin
        cur = exp_q.pop_front();
        check("start_cycle", cyc, cur.cyc);
        in_frame = 1'b1;
        errs     = (tx === 1'b0) ? 0 : 1;
        pos      = 1;
      end
    end
  end

  task automatic wait_accept();
    int start;
    start = accept_cnt;
    for (int i = 0; i < 3 * FB * DIV; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt != start) break;
    end
    check("accept_within_budget", int'(accept_cnt != start), 1);
  endtask

  task automatic send(logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    wait_accept();
    @(negedge clk);
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * FB * DIV; i++) begin
      @(negedge clk);
      #1;
      if (!in_frame && exp_q.size() == 0 && ready) break;
    end
    check("drained", int'(in_frame) + exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid = ~valid;
      data  = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold_tx", int'(tx), 1);
      check("rst_hold_ready", int'(ready), 1);
    end
    @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_tx", int'(tx), 1);

    send(8'h55);
    wait_idle();
    send(8'hA3);
    wait_idle();

    // bytes offered while busy are dropped
    send(8'h0F);
    repeat (3 * DIV) @(negedge clk);
    valid = 1'b1;
    data  = 8'hFF;
    repeat (2) @(negedge clk);
    valid = 1'b0;
    wait_idle();
    repeat (FB * DIV) @(negedge clk);

    // valid held high across two frames
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h41;
    wait_accept();
    @(negedge clk);
    data = 8'h42;
    wait_accept();
    @(negedge clk);
    valid = 1'b0;
    wait_idle();

    // asynchronous reset in the middle of a frame
    send(8'h3C);
    repeat (4 * DIV) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    send(8'h96);
    wait_idle();

    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 2 * DIV)) @(negedge clk);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, FB * DIV)) @(negedge clk);
        valid = 1'b1;
        data  = 8'($urandom);
        @(negedge clk);
        valid = 1'b0;
      end
    end
    wait_idle();
    repeat (2 * DIV) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
